// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// mem_arb : two-master round-robin arbiter for the shared data-memory/MMIO port
// Revision : 1.0  initial release
// ============================================================================
module mem_arb #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   output logic          s_we,
   output logic          s_re,
   input  logic [DW-1:0] s_rdata,
   output logic          busy,
   output logic          owner
);

   localparam int c_CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(RD_LAT - 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   logic [1:0]         r_state;
   logic               r_we;
   logic [AW-1:0]      r_addr;
   logic [DW-1:0]      r_wdata;
   logic [DW-1:0]      r_rdata;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_last;
   logic               r_owner;
   logic               w_win;

   // m1 wins when alone, or in a contest when m0 was served last.
   assign w_win = m1_req & (~m0_req | ~r_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
         r_last  <= 1'b1;
         r_owner <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (m0_req || m1_req) begin
                  r_owner <= w_win;
                  r_last  <= w_win;
                  r_we    <= w_win ? m1_we    : m0_we;
                  r_addr  <= w_win ? m1_addr  : m0_addr;
                  r_wdata <= w_win ? m1_wdata : m0_wdata;
                  r_state <= c_ISSUE;
               end
            end
            c_ISSUE: begin
               if (r_we) begin
                  r_state <= c_DONE;
               end else begin
                  r_cnt   <= c_CNT_INIT;
                  r_state <= c_WAIT;
               end
            end
            c_WAIT: begin
               if (r_cnt == '0) begin
                  r_rdata <= s_rdata;
                  r_state <= c_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // Strobes and acks decode the registered state so reset clears them at once.
   assign s_we     = (r_state == c_ISSUE) &  r_we;
   assign s_re     = (r_state == c_ISSUE) & ~r_we;
   assign m0_ack   = (r_state == c_DONE)  & ~r_owner;
   assign m1_ack   = (r_state == c_DONE)  &  r_owner;
   assign busy     = (r_state != c_IDLE);
   assign owner    = r_owner;
   assign s_addr   = r_addr;
   assign s_wdata  = r_wdata;
   assign m0_rdata = r_rdata;
   assign m1_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// tb_mem_arb : self-checking bench for mem_arb with a cycle-timeline model
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arb;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int RD_LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_ack, m1_ack, s_we, s_re, busy, owner;
   logic [DW-1:0] m0_rdata, m1_rdata, s_wdata;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_rdata = '0;

   mem_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_re(s_re),
      .s_rdata(s_rdata), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: each transaction is a grant cycle g and a completion cycle d.
   int          g = -1, d = -1;
   logic        m_we = 1'b0, m_own = 1'b0, m_last = 1'b1, w = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
   bit          ack_own[$];
   int          ack_at[$];
   int          rd_due = -100;
   logic [31:0] rd_val = '0;

   // Slave: returns addressed data exactly RD_LAT cycles after s_re, junk otherwise.
   always @(posedge clk) begin
      #1;
      if (cyc == rd_due) s_rdata = rd_val;
      else               s_rdata = {16'hBAD0, cyc[15:0]};
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_s_we", s_we, 0);       chk("rst_s_re", s_re, 0);
         chk("rst_m0_ack", m0_ack, 0);   chk("rst_m1_ack", m1_ack, 0);
         chk("rst_busy", busy, 0);       chk("rst_owner", owner, 0);
         chk("rst_s_addr", s_addr, 0);   chk("rst_s_wdata", s_wdata, 0);
         chk("rst_rdata", m0_rdata, 0);
         g = -1; d = -1; m_last = 1'b1; m_own = 1'b0; m_we = 1'b0;
         m_addr = '0; m_wdata = '0; m_rdata = '0; rd_due = -100;
      end else begin
         chk("s_we",   s_we,   (cyc == g + 1) && m_we);
         chk("s_re",   s_re,   (cyc == g + 1) && !m_we);
         chk("m0_ack", m0_ack, (cyc == d) && !m_own);
         chk("m1_ack", m1_ack, (cyc == d) && m_own);
         chk("busy",   busy,   (cyc > g) && (cyc <= d));
         chk("owner",  owner,  m_own);
         chk("s_addr", s_addr, m_addr);
         chk("s_wdata", s_wdata, m_wdata);
         if (cyc == d) begin
            chk("m0_rdata", m0_rdata, m_rdata);
            chk("m1_rdata", m1_rdata, m_rdata);
         end
         if (m0_ack) begin ack_own.push_back(1'b0); ack_at.push_back(cyc); end
         if (m1_ack) begin ack_own.push_back(1'b1); ack_at.push_back(cyc); end
         if (s_re) begin
            rd_due = cyc + RD_LAT;
            rd_val = (s_addr == 32'h10) ? 32'hDEADBEEF : (s_addr ^ 32'hC0DE0000);
         end
         if (!m_we && cyc == d - 1 && cyc > g) m_rdata = s_rdata;
         if (cyc > d && (m0_req || m1_req)) begin
            w       = (m0_req && m1_req) ? !m_last : m1_req;
            m_own   = w;
            m_last  = w;
            m_we    = w ? m1_we    : m0_we;
            m_addr  = w ? m1_addr  : m0_addr;
            m_wdata = w ? m1_wdata : m0_wdata;
            g = cyc;
            d = cyc + 2 + (m_we ? 0 : RD_LAT);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Waits for n more acks, then returns just after the edge that samples the last one.
   task automatic wait_acks(input int n, input int budget);
      int start = ack_own.size();
      int t = 0;
      while (ack_own.size() < start + n && t < budget) begin
         @(negedge clk); #1;
         t++;
      end
      chk("wait_acks_timeout", ack_own.size() >= start + n, 1);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // 1: m0 write to the display register
      m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h1234;
      @(negedge clk); chk("t1_swe_k", s_we, 0);
      @(negedge clk);
      chk("t1_swe_k1", s_we, 1);      chk("t1_sre_k1", s_re, 0);
      chk("t1_saddr", s_addr, 32'h20); chk("t1_swdata", s_wdata, 32'h1234);
      @(negedge clk);
      chk("t1_m0ack_k2", m0_ack, 1);  chk("t1_m1ack_k2", m1_ack, 0);
      tick(); m0_req = 0;

      // 2: m1 read, data returned two cycles after the strobe
      m1_req = 1; m1_we = 0; m1_addr = 32'h10;
      @(negedge clk);
      @(negedge clk); chk("t2_sre_k1", s_re, 1); chk("t2_swe_k1", s_we, 0);
      @(negedge clk);
      @(negedge clk); chk("t2_m1ack_k3", m1_ack, 0);
      @(negedge clk);
      chk("t2_m1ack_k4", m1_ack, 1); chk("t2_rdata", m1_rdata, 32'hDEADBEEF);
      tick(); m1_req = 0;

      // 3: both masters write continuously from reset release
      rst_n = 0;
      m0_req = 1; m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'hA;
      m1_req = 1; m1_we = 1; m1_addr = 32'h104; m1_wdata = 32'hB;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      n0 = ack_own.size();
      wait_acks(4, 40);
      m0_req = 0; m1_req = 0;
      for (int i = 0; i < 4; i++) begin
         if (ack_own.size() > n0 + i) chk("t3_owner_seq", ack_own[n0+i], i % 2);
         else chk("t3_ack_missing", ack_own.size(), n0 + i + 1);
         if (i > 0 && ack_at.size() > n0 + i)
            chk("t3_ack_spacing", ack_at[n0+i] - ack_at[n0+i-1], 3);
      end

      // 4: m1 joins during m0's ISSUE and is served next
      m0_req = 1; m0_we = 1; m0_addr = 32'h200; m0_wdata = 32'hC0;
      n0 = ack_own.size();
      tick();
      m1_req = 1; m1_we = 0; m1_addr = 32'h44;
      wait_acks(3, 60);
      m0_req = 0; m1_req = 0;
      for (int i = 0; i < 3; i++) begin
         if (ack_own.size() > n0 + i) chk("t4_owner_seq", ack_own[n0+i], i % 2);
         else chk("t4_ack_missing", ack_own.size(), n0 + i + 1);
      end

      // 5: reset lands in the WAIT of an m1 read
      m1_req = 1; m1_we = 0; m1_addr = 32'h30;
      tick(); m1_req = 0;
      tick();
      chk("t5_busy_pre", busy, 1); chk("t5_owner_pre", owner, 1);
      #1 rst_n = 0;
      #1;
      chk("t5_async_swe", s_we, 0);   chk("t5_async_sre", s_re, 0);
      chk("t5_async_ack0", m0_ack, 0); chk("t5_async_ack1", m1_ack, 0);
      chk("t5_async_busy", busy, 0);  chk("t5_async_owner", owner, 0);
      chk("t5_async_saddr", s_addr, 0); chk("t5_async_rdata", m1_rdata, 0);
      m0_req = 1; m0_we = 1; m0_addr = 32'h300; m0_wdata = 32'h77;
      m1_req = 1; m1_we = 1; m1_addr = 32'h304; m1_wdata = 32'h88;
      n0 = ack_own.size();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      wait_acks(1, 20);
      m0_req = 0; m1_req = 0;
      if (ack_own.size() > n0) chk("t5_first_after_rst", ack_own[n0], 0);
      else chk("t5_ack_missing", ack_own.size(), n0 + 1);

      // 6: m0 drops req during ISSUE; still acked once, not reissued
      tick();
      m0_req = 1; m0_we = 1; m0_addr = 32'h24; m0_wdata = 32'h55;
      tick(); m0_req = 0;
      @(negedge clk); chk("t6_swe_k1", s_we, 1);
      @(negedge clk); chk("t6_m0ack_k2", m0_ack, 1);
      repeat (4) begin
         @(negedge clk);
         chk("t6_no_reissue_we", s_we, 0); chk("t6_no_reissue_busy", busy, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mem_arb.md
# mem_arb

Two-master arbiter that shares the single data-memory/MMIO port (the write/read port feeding the memory controller and its display register at address 0x20) between the CPU data port (master 0) and a debug/DMA loader (master 1). It grants one transaction at a time with round-robin fairness. It drives one registered strobe to the slave, waits a fixed read latency, and returns a one-cycle acknowledge with read data to the owning master.

## Interface
- AW, 32, address width
- DW, 32, data width
- RD_LAT, 1, cycles from slave read strobe to valid s_rdata; legal range is ≥1
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  transaction request, held until ack
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  AW  address
- m0_wdata, m1_wdata  in  DW  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DW  read data, valid while the matching ack=1
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_we  out  1  slave write strobe, one cycle
- s_re  out  1  slave read strobe, one cycle
- s_rdata  in  DW  slave read data
- busy  out  1  state != IDLE
- owner  out  1  index of the master currently granted

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any req=1, pick a winner and latch its we/addr/wdata into we_r/addr_r/wdata_r.
  - Set owner to the winner, set last to the winner, go to ISSUE.
  - If no req is high, stay in IDLE.
- **Arbitration**
  - Single requester wins.
  - When both request, the master != last wins.
  - Reset value of last is 1, so m0 wins the first contest.
- **ISSUE** (exactly one cycle)
  - s_we = we_r, s_re = !we_r.
  - Write: go to DONE.
  - Read: load cnt = RD_LAT-1 and go to WAIT.
- **WAIT**
  - When cnt == 0, capture s_rdata into rdata_r and go to DONE.
  - Otherwise decrement cnt.
- **DONE** (one cycle)
  - Owner's ack = 1, then go to IDLE.
  - The non-owner's ack is never asserted.
- **Payload and outputs**
  - s_addr = addr_r and s_wdata = wdata_r. They hold their values after the transaction and are reset to 0.
  - m0_rdata and m1_rdata both carry rdata_r. A write leaves rdata_r unchanged.
- **Requester rules**
  - Payload is sampled only at the grant edge in IDLE.
  - The requester must drop req at the edge where it samples ack=1. A req still high in the following IDLE cycle is treated as a new transaction.
  - If req drops after the grant, the transaction still completes and ack still pulses.
  - A req that drops while not granted is simply not served.
- **Reset**
  - rst_n=0 forces immediately, regardless of clk: state=IDLE, and s_we, s_re, acks, busy, owner, s_addr, s_wdata, rdata_r, cnt all = 0, last=1.
  - An in-flight transaction is abandoned with no ack. The slave may already have seen its strobe.

## Timing
- Request visible in IDLE cycle k:
  - ISSUE (strobe) in cycle k+1.
  - Write ack in cycle k+2.
  - Read ack in cycle k+2+RD_LAT.
- Slave contract: s_rdata is valid in cycle k+1+RD_LAT, which is the last WAIT cycle.
- Throughput:
  - The next grant can occur no earlier than the IDLE cycle after DONE.
  - Back-to-back writes complete one per 3 cycles.
  - Back-to-back reads complete one per 3+RD_LAT cycles.
- Strobes are exactly one cycle long and are never asserted outside ISSUE.
- At most one ack is high in any cycle.
- busy is high from ISSUE through DONE inclusive.

## Test plan
1. m0 write addr=0x20, wdata=0x00001234 with m1 idle, request in cycle k.
   - s_we=1 only in k+1, with s_addr=0x20 and s_wdata=0x1234.
   - m0_ack=1 only in k+2; m1_ack stays 0; s_re stays 0.
2. RD_LAT=2, m1 read addr=0x10, slave drives 0xDEADBEEF in the cycle two after s_re.
   - s_re=1 only in k+1.
   - m1_ack in k+4 with m1_rdata=0xDEADBEEF.
3. Both masters issue writes with req held continuously from reset release.
   - Grants alternate m0, m1, m0, m1.
   - Acks arrive 3 cycles apart; owner toggles each transaction.
4. m0 requests continuously; m1 asserts req during m0's ISSUE.
   - The next grant goes to m1, then m0.
   - m1 is never starved past one m0 transaction.
5. rst_n pulled low during WAIT of a read.
   - All outputs read 0 without waiting for a clk edge; no ack ever appears for that read.
   - After release with both requesting, m0 is granted first.
6. m0 drops req in the cycle after its grant (during ISSUE).
   - m0_ack still pulses in k+2.
   - No second transaction is issued for m0.
